// File: rtl/adder_pkg.sv
// adder_pkg -- shared types and constants for the chunked serial adder.
//   state_e          : controller states IDLE / RUN / DONE
//   ADDER_WIDTH_DFLT : default operand width
//   ADDER_CHUNK_DFLT : default bits added per clock
//   full_add()       : one-bit full-adder cell, returns {carry_out, sum}
package adder_pkg;

   localparam int ADDER_WIDTH_DFLT = 16;
   localparam int ADDER_CHUNK_DFLT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk -- combinational CHUNK-bit ripple adder made of full-adder cells.
// Ports:
//   a_i, b_i [CHUNK] : operand slices
//   cin_i            : carry into bit 0
//   s_o    [CHUNK]   : sum slice
//   cout_o           : carry out of the top bit
//   cmsb_o           : carry into the top bit (for signed-overflow detection)
module adder_chunk
   import adder_pkg::*;
#(
   parameter int CHUNK = ADDER_CHUNK_DFLT
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] s_o,
   output logic             cout_o,
   output logic             cmsb_o
);

   logic [CHUNK:0] carry;

   always_comb begin
      carry    = '0;
      s_o      = '0;
      carry[0] = cin_i;
      for (int i = 0; i < CHUNK; i++) begin
         {carry[i+1], s_o[i]} = full_add(a_i[i], b_i[i], carry[i]);
      end
   end

   assign cout_o = carry[CHUNK];
   assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/adder_serial.sv
// adder_serial -- serial adder that processes CHUNK bits per clock with a
// valid/ready handshake on both sides.
// Optional feature: define ADDER_SERIAL_SUB_EN to add the 'sub' port
// (sub=1 computes a - b as a + ~b + 1, cin ignored, cout=1 means no borrow).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b [WIDTH], cin   : operands and carry in
//   sub                 : subtract select (only with ADDER_SERIAL_SUB_EN)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum [WIDTH], cout   : result and final carry
//   ovf                 : signed overflow
//
// state | meaning
// IDLE  | ready for operands; captures a/b/cin on in_valid
// RUN   | adds one CHUNK slice per clock, N = WIDTH/CHUNK cycles
// DONE  | result valid and held until out_ready
module adder_serial
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DFLT,
   parameter int CHUNK = ADDER_CHUNK_DFLT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADDER_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("adder_serial: WIDTH (%0d) must be a nonzero multiple of CHUNK (%0d)", WIDTH, CHUNK);
   end

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [CHUNK-1:0] chunk_s;
   logic             chunk_cout;
   logic             chunk_cmsb;
   logic             last_chunk;

   // Subtraction is folded in at capture time so the datapath only ever adds.
`ifdef ADDER_SERIAL_SUB_EN
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub ? 1'b1 : cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   // Operands shift right each RUN cycle, so the active slice is always bits [CHUNK-1:0].
   adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i    (a_q[CHUNK-1:0]),
      .b_i    (b_q[CHUNK-1:0]),
      .cin_i  (carry_q),
      .s_o    (chunk_s),
      .cout_o (chunk_cout),
      .cmsb_o (chunk_cmsb)
   );

   assign last_chunk = (cnt_q == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b_eff;
               carry_d = cin_eff;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            // New slice enters at the top; after N cycles it has reached its final position.
            sum_d   = (sum_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));
            carry_d = chunk_cout;
            cnt_d   = cnt_q + CW'(1);
            if (last_chunk) begin
               ovf_d   = chunk_cmsb ^ chunk_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = carry_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_serial.sv
module tb_adder_serial;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   in_valid = '0;
   logic [2:0]   out_ready = '0;
   logic [2:0]   in_ready, out_valid, cout_w, ovf_w;
   logic [W-1:0] a_s = '0, b_s = '0;
   logic         cin_s = 1'b0;
`ifdef ADDER_SERIAL_SUB_EN
   logic         sub_s = 1'b0;
`endif
   logic [W-1:0] sum_w [3];

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   // index 0: CHUNK=1, index 1: CHUNK=4, index 2: CHUNK=16
   adder_serial #(.WIDTH(W), .CHUNK(1)) u_dut_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a_s), .b(b_s), .cin(cin_s),
`ifdef ADDER_SERIAL_SUB_EN
      .sub(sub_s),
`endif
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));

   adder_serial #(.WIDTH(W), .CHUNK(4)) u_dut_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a_s), .b(b_s), .cin(cin_s),
`ifdef ADDER_SERIAL_SUB_EN
      .sub(sub_s),
`endif
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));

   adder_serial #(.WIDTH(W), .CHUNK(16)) u_dut_c16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a_s), .b(b_s), .cin(cin_s),
`ifdef ADDER_SERIAL_SUB_EN
      .sub(sub_s),
`endif
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference: plain integer arithmetic; overflow from operand/result signs.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
      logic [W-1:0] yy;
      logic         cc;
      logic [W:0]   r;
      logic         o;
      yy = s ? ~y : y;
      cc = s ? 1'b1 : c;
      r  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
      o  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
      return {o, r};
   endfunction

   // One transaction on instance idx. Returns {ovf, cout, sum}; when hold=1 the
   // result is left in DONE (out_ready not asserted).
   task automatic txn(input int idx, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic c, input logic s, input bit hold, input string tag,
                      output logic [W+1:0] got);
      int n, lat, bad, guard;
      logic [W+1:0] exp;
      n     = (idx == 0) ? 16 : (idx == 1) ? 4 : 1;
      exp   = model(x, y, c, s);
      guard = 0;
      while (!in_ready[idx] && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      chk({tag, "_ready"}, 32'(in_ready[idx]), 32'd1);
      a_s   = x;
      b_s   = y;
      cin_s = c;
`ifdef ADDER_SERIAL_SUB_EN
      sub_s = s;
`endif
      in_valid[idx] = 1'b1;
      @(posedge clk); #1;
      in_valid[idx] = 1'b0;
      lat = 0;
      bad = 0;
      while (!out_valid[idx] && lat < n + 8) begin
         if (in_ready[idx]) bad++;
         @(posedge clk); #1; lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(n));
      chk({tag, "_busy_ready"}, 32'(bad), 32'd0);
      chk({tag, "_done_ready"}, 32'(in_ready[idx]), 32'd0);
      got = {ovf_w[idx], cout_w[idx], sum_w[idx]};
      chk({tag, "_result"}, 32'(got), 32'(exp));
      if (!hold) begin
         out_ready[idx] = 1'b1;
         @(posedge clk); #1;
         out_ready[idx] = 1'b0;
         chk({tag, "_back_idle"}, {30'd0, out_valid[idx], in_ready[idx]}, 32'b01);
      end
   endtask

   initial begin
      logic [W+1:0] got;
      logic         seen;
      logic [W-1:0] ra, rb;
      logic         rc, rs;

      // Reset values, checked while reset is still asserted.
      #3;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_ctl%0d", i), {30'd0, out_valid[i], in_ready[i]}, 32'b01);
         chk($sformatf("reset_res%0d", i), {14'd0, ovf_w[i], cout_w[i], sum_w[i]}, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed corner cases on the CHUNK=4 instance.
      txn(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "wrap", got);
      chk("wrap_sum_cout_ovf", 32'(got), {14'd0, 1'b0, 1'b1, 16'h0000});
      txn(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "sovf", got);
      chk("sovf_sum_cout_ovf", 32'(got), {14'd0, 1'b1, 1'b0, 16'h8000});

      // Result held in DONE while out_ready is low; new in_valid must be ignored.
      txn(1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, "hold", got);
      chk("hold_sum_cout", 32'(got[W:0]), {15'd0, 1'b0, 16'h5556});
      a_s = 16'hAAAA;
      b_s = 16'h5555;
      in_valid[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("hold_ctl_c%0d", k), {30'd0, out_valid[1], in_ready[1]}, 32'b10);
         chk($sformatf("hold_sum_c%0d", k), 32'(sum_w[1]), 32'h5556);
      end
      in_valid[1]  = 1'b0;
      out_ready[1] = 1'b1;
      @(posedge clk); #1;
      out_ready[1] = 1'b0;
      chk("hold_release", {30'd0, out_valid[1], in_ready[1]}, 32'b01);
      @(posedge clk); #1;
      chk("hold_no_capture", {30'd0, out_valid[1], in_ready[1]}, 32'b01);

      // Reset in the second RUN cycle abandons the operation.
      a_s = 16'h1111;
      b_s = 16'h2222;
      cin_s = 1'b1;
`ifdef ADDER_SERIAL_SUB_EN
      sub_s = 1'b0;
`endif
      in_valid[1] = 1'b1;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      chk("rst_run_ctl", {30'd0, out_valid[1], in_ready[1]}, 32'b01);
      chk("rst_run_res", {14'd0, ovf_w[1], cout_w[1], sum_w[1]}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         seen = seen | out_valid[1];
      end
      chk("rst_no_result", 32'(seen), 32'd0);
      chk("rst_outputs_zero", {14'd0, ovf_w[1], cout_w[1], sum_w[1]}, 32'd0);
      txn(1, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, "post_rst", got);
      chk("post_rst_sum", 32'(got[W-1:0]), 32'h0005);

`ifdef ADDER_SERIAL_SUB_EN
      txn(1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, "sub_borrow", got);
      chk("sub_borrow_sum_cout", 32'(got[W:0]), {15'd0, 1'b0, 16'hFFFE});
      txn(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, "sub_ovf", got);
      chk("sub_ovf_sum_ovf", {15'd0, got[W+1], got[W-1:0]}, {15'd0, 1'b1, 16'h7FFF});
`endif

      // Random back-to-back traffic across CHUNK = 1, 4, 16.
      for (int t = 0; t < 1000; t++) begin
         ra = 16'($urandom());
         rb = 16'($urandom());
         rc = 1'($urandom_range(0, 1));
`ifdef ADDER_SERIAL_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         txn(t % 3, ra, rb, rc, rs, 1'b0, $sformatf("rnd%0d_c%0d", t, t % 3), got);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion, %0d/%0d checks passed",
               pass_cnt, total_cnt);
      $fatal(1, "simulation timeout");
   end

endmodule
